// File: rtl/lisp_rx_reassemble_pkg.sv
// lisp_rx_reassemble_pkg: tag codes, LISP header field positions and FSM encoding shared by rx and tx paths
package lisp_rx_reassemble_pkg;
  localparam logic [2:0] TAG_FIRST = 3'b101;
  localparam logic [2:0] TAG_MID = 3'b100;
  localparam logic [2:0] TAG_LAST = 3'b110;
  localparam int FRAG_F_HI = 79;
  localparam int FRAG_F_LO = 72;
  localparam int FRAG_S_HI = 55;
  localparam int FRAG_S_LO = 48;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;
endpackage

// File: rtl/lisp_rx_reassemble_sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  // count one per cycle with inc high, holding once saturated
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/lisp_rx_reassemble.sv
// lisp_rx_reassemble: strips LISP encapsulation and rejoins two-fragment packets toward the UM FIFO
module lisp_rx_reassemble
  import lisp_rx_reassemble_pkg::*;
#(
  parameter int HDR_WORDS = 5,
  parameter int USEDW_TH = 160,
  parameter int FRAG_TIMEOUT = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             cdp2um_data_valid,
  input  logic [138:0]     cdp2um_data,
  output logic             um2cdp_rx_enable,
  input  logic [7:0]       um_usedw,
  output logic             um_data_valid,
  output logic [138:0]     um_data,
  output logic             um_data_err,
  output logic [CNT_W-1:0] frag_drop_cnt,
  output logic [CNT_W-1:0] runt_cnt
);
  localparam int HW = $clog2(HDR_WORDS + 1);
  localparam int TW = $clog2(FRAG_TIMEOUT);
  logic [1:0] state, state_n;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tcnt;
  logic first_pend, frag0, frag_pend;
  logic [2:0] tag, out_tag;
  logic [7:0] f_fld, s_fld;
  logic in_hdr, is_last, runt, hdr_done, frag0_hdr, frag1_hdr, timing, expire, abandon, drop_hdr, fwd;
  // decode the current word and decide abandon / drop / forward and the next state
  always_comb begin
    tag = cdp2um_data[138:136];
    f_fld = cdp2um_data[FRAG_F_HI:FRAG_F_LO];
    s_fld = cdp2um_data[FRAG_S_HI:FRAG_S_LO];
    is_last = cdp2um_data_valid && tag == TAG_LAST;
    in_hdr = mode && cdp2um_data_valid && state == ST_HDR;
    runt = in_hdr && is_last;
    hdr_done = in_hdr && !is_last && hcnt == HW'(HDR_WORDS - 1);
    frag0_hdr = f_fld == 8'd1 && s_fld == 8'd0;
    frag1_hdr = f_fld == 8'd1 && s_fld == 8'd1;
    timing = frag_pend && (state == ST_IDLE || state == ST_HDR);
    expire = timing && tcnt == TW'(FRAG_TIMEOUT - 1);
    abandon = mode && frag_pend && (expire || runt || (hdr_done && !frag1_hdr));
    drop_hdr = hdr_done && (frag1_hdr ? (!frag_pend || expire) : !(f_fld == 8'd0 || frag0_hdr));
    fwd = mode && cdp2um_data_valid && state == ST_BODY;
    out_tag = is_last ? (frag0 ? TAG_MID : TAG_LAST) : (first_pend ? TAG_FIRST : TAG_MID);
    state_n = !mode ? ST_IDLE : !cdp2um_data_valid ? state :
              state == ST_IDLE ? (tag == TAG_FIRST ? ST_HDR : ST_IDLE) :
              state == ST_HDR ? (runt ? ST_IDLE : !hdr_done ? ST_HDR : drop_hdr ? ST_DROP : ST_BODY) :
              is_last ? ST_IDLE : state;
  end
  // packet state, header word count, fragment bookkeeping and reassembly timeout
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      hcnt <= '0;
      tcnt <= '0;
      first_pend <= 1'b0;
      frag0 <= 1'b0;
      frag_pend <= 1'b0;
    end else begin
      state <= state_n;
      hcnt <= state == ST_HDR ? hcnt + HW'(in_hdr) : HW'(1);
      tcnt <= (fwd && is_last) ? '0 : timing ? tcnt + TW'(1) : tcnt;
      first_pend <= hdr_done ? !frag1_hdr : fwd ? 1'b0 : first_pend;
      frag0 <= hdr_done ? frag0_hdr : frag0;
      frag_pend <= mode && !abandon && ((fwd && is_last) ? frag0 : frag_pend);
    end
  // registered output: pass-through, pad word on abandon, or retagged body word
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      um2cdp_rx_enable <= 1'b0;
      um_data_valid <= 1'b0;
      um_data_err <= 1'b0;
      um_data <= '0;
    end else begin
      um2cdp_rx_enable <= um_usedw < 8'(USEDW_TH);
      um_data_valid <= mode ? (fwd || abandon) : cdp2um_data_valid;
      um_data_err <= abandon;
      um_data <= !mode ? cdp2um_data : abandon ? {TAG_LAST, 136'd0} : fwd ? {out_tag, cdp2um_data[135:0]} : '0;
    end
  sat_counter #(.CNT_W(CNT_W)) u_frag_cnt (.clk(clk), .reset(reset), .inc(abandon || drop_hdr), .count(frag_drop_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_runt_cnt (.clk(clk), .reset(reset), .inc(runt), .count(runt_cnt));
endmodule

// File: tb/tb_lisp_rx_reassemble.sv
// tb_lisp_rx_reassemble: randomized self-checking bench against a packet-level model of the rx reassembler
module tb_lisp_rx_reassemble;
  localparam int N = 1024;
  logic clk = 1'b0, reset = 1'b0, mode = 1'b1, cdp2um_data_valid = 1'b0;
  logic [138:0] cdp2um_data = '0;
  logic [7:0] um_usedw = 8'd159;
  logic um2cdp_rx_enable, um_data_valid, um_data_err;
  logic [138:0] um_data;
  logic [15:0] frag_drop_cnt, runt_cnt;
  int cyc = 0, n_chk = 0, n_fail = 0, n_out = 0;
  typedef struct {logic [138:0] d; logic err; int e;} exp_t;
  exp_t q[$];
  bit pend = 0;
  int pend_edge = 0, fd_m = 0, runt_m = 0, fd_last = -1;

  lisp_rx_reassemble dut (
    .clk(clk), .reset(reset), .mode(mode),
    .cdp2um_data_valid(cdp2um_data_valid), .cdp2um_data(cdp2um_data),
    .um2cdp_rx_enable(um2cdp_rx_enable), .um_usedw(um_usedw),
    .um_data_valid(um_data_valid), .um_data(um_data), .um_data_err(um_data_err),
    .frag_drop_cnt(frag_drop_cnt), .runt_cnt(runt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_exp(input logic [138:0] d, input logic err, input int e);
    exp_t x;
    x.d = d;
    x.err = err;
    x.e = e;
    q.push_back(x);
  endfunction

  function automatic void bump_fd(input int e);
    if (e != fd_last) begin
      fd_m++;
      fd_last = e;
    end
  endfunction

  function automatic void abandon_m(input int e);
    push_exp({3'b110, 136'd0}, 1'b1, e);
    bump_fd(e);
    pend = 0;
  endfunction

  function automatic void timeout_m(input int e);
    if (pend && e == pend_edge + N) abandon_m(e);
  endfunction

  function automatic logic [135:0] rnd136();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[135:0];
  endfunction

  task automatic drive(input logic v, input logic [138:0] w);
    timeout_m(cyc + 1);
    if (!mode && v) push_exp(w, 1'b0, cyc + 1);
    cdp2um_data_valid = v;
    cdp2um_data = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, {3'b000, rnd136()});
  endtask

  task automatic send_pkt(input int f, input int s, input int nbody, input int rlen, input int cut, input int gap);
    int len, last;
    bit fwd, first, frag0;
    logic [135:0] p;
    logic [2:0] t;
    len = rlen > 0 ? rlen : 5 + nbody;
    last = cut > 0 ? cut : len;
    fwd = 0;
    first = 0;
    frag0 = 0;
    for (int i = 1; i <= last; i++) begin
      repeat ($urandom_range(0, gap)) idle(1);
      p = rnd136();
      if (i == 5) begin
        p[79:72] = 8'(f);
        p[55:48] = 8'(s);
      end
      t = i == 1 ? 3'b101 : i == len ? 3'b110 : 3'b100;
      timeout_m(cyc + 1);
      if (i == len && len <= 5) begin
        runt_m++;
        if (pend) abandon_m(cyc + 1);
      end else if (i == 5) begin
        if (pend && f == 1 && s == 1) begin
          pend = 0;
          fwd = 1;
        end else begin
          if (pend) abandon_m(cyc + 1);
          fwd = f == 0 || (f == 1 && s == 0);
          first = fwd;
          frag0 = f == 1 && s == 0;
          if (!fwd) bump_fd(cyc + 1);
        end
      end else if (i > 5 && fwd) begin
        push_exp({i == len ? (frag0 ? 3'b100 : 3'b110) : ((i == 6 && first) ? 3'b101 : 3'b100), p}, 1'b0, cyc + 1);
        if (i == len && frag0) begin
          pend = 1;
          pend_edge = cyc + 1;
        end
      end
      drive(1'b1, {t, p});
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_frag_drop_cnt"}, frag_drop_cnt, fd_m);
    check({tag, "_runt_cnt"}, runt_cnt, runt_m);
  endtask

  always @(negedge clk) if (reset) begin
    if (q.size() > 0 && q[0].e == cyc) begin
      check("out_word", {um_data_valid, um_data_err, um_data}, {1'b1, q[0].err, q[0].d});
      n_out++;
      void'(q.pop_front());
    end else if (um_data_valid)
      check("spurious_word", {um_data_valid, um_data_err, um_data}, 141'd0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, v, f, s, r;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", um_data_valid, 0);
    check("rst_data", um_data, 0);
    check("rst_err", um_data_err, 0);
    check("rst_rx_enable", um2cdp_rx_enable, 0);
    check_cnts("rst");
    reset = 1'b1;
    idle(1);
    check("rx_enable_159", um2cdp_rx_enable, 1);
    um_usedw = 8'd160;
    idle(1);
    check("rx_enable_160", um2cdp_rx_enable, 0);
    um_usedw = 8'($urandom_range(0, 159));
    idle(1);
    check("rx_enable_low", um2cdp_rx_enable, 1);
    um_usedw = 8'd255;
    idle(1);
    check("rx_enable_full", um2cdp_rx_enable, 0);
    um_usedw = 8'd20;

    base = n_out;
    send_pkt(0, 0, 8, 0, 0, 0);
    idle(3);
    check("unfrag_words", n_out - base, 8);
    check_cnts("unfrag");

    base = n_out;
    send_pkt(1, 0, 64, 0, 0, 0);
    send_pkt(1, 1, 20, 0, 0, 0);
    idle(3);
    check("join_words", n_out - base, 84);
    check("join_frag_drop", frag_drop_cnt, 0);

    base = n_out;
    send_pkt(1, 1, 6, 0, 0, 1);
    idle(3);
    check("orphan_words", n_out - base, 0);
    check("orphan_frag_drop", frag_drop_cnt, 1);

    base = n_out;
    send_pkt(1, 0, 10, 0, 0, 0);
    send_pkt(0, 0, 3, 0, 0, 0);
    idle(3);
    check("abandon_words", n_out - base, 14);
    check("abandon_frag_drop", frag_drop_cnt, 2);

    base = n_out;
    send_pkt(1, 0, 4, 0, 0, 0);
    idle(N + 4);
    check("timeout_words", n_out - base, 5);
    check("timeout_frag_drop", frag_drop_cnt, 3);
    base = n_out;
    send_pkt(0, 0, 0, 3, 0, 0);
    idle(3);
    check("runt_words", n_out - base, 0);
    check("runt_cnt", runt_cnt, 1);
    check_cnts("directed");

    mode = 1'b0;
    base = n_out;
    r = 0;
    for (int k = 0; k < 40; k++) begin
      v = $urandom_range(0, 1);
      r += v;
      drive(v[0], {3'($urandom()), rnd136()});
    end
    idle(2);
    mode = 1'b1;
    check("echo_words", n_out - base, r);

    send_pkt(0, 0, 10, 0, 8, 0);
    reset = 1'b0;
    q.delete();
    pend = 0;
    fd_m = 0;
    runt_m = 0;
    fd_last = -1;
    #1;
    check("midrst_valid", um_data_valid, 0);
    check("midrst_data", um_data, 0);
    check_cnts("midrst");
    @(posedge clk);
    #1;
    reset = 1'b1;
    base = n_out;
    send_pkt(0, 0, 5, 0, 0, 0);
    idle(3);
    check("post_rst_words", n_out - base, 5);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 11);
      f = ($urandom_range(0, 3) == 0) ? 0 : (($urandom_range(0, 4) == 0) ? 2 : 1);
      s = ($urandom_range(0, 4) == 0) ? 3 : $urandom_range(0, 1);
      if (r == 0) send_pkt(0, 0, 0, $urandom_range(2, 5), 0, 2);
      else if (r == 1) idle(N + $urandom_range(0, 8));
      else send_pkt(f, s, $urandom_range(1, 12), 0, 0, 2);
    end
    idle(N + 10);
    check_cnts("random");
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
